// File: rtl/apb_cmd_master.sv
// apb_cmd_master
// Turns a simple valid/ready command stream into single APB transfers and
// returns one response per command. One transfer is outstanding at a time.
//
// Parameters
//   ADDR_WIDTH  width of cmd_addr / PADDR (3..32)
//   TIMEOUT     ACCESS cycles allowed without PREADY before aborting;
//               0 waits forever (0..65535)
//
// Ports
//   PCLK, PRESET        clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_write, cmd_addr, cmd_wdata payload
//   rsp_valid/ready     response handshake; rsp_rdata, rsp_err, rsp_timeout payload
//   PADDR, PSEL, PENABLE, PWRITE, PWDATA   APB initiator outputs (all registered)
//   PRDATA, PREADY, PSLVERR                APB completer inputs
module apb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic        TO_EN   = (TIMEOUT != 0);
    // Value of the wait counter on the last permitted ACCESS cycle.
    localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [15:0]             wait_q, wait_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [31:0]             pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    // Every output is computed for the next state so it comes straight
    // from a flop.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = cmd_write;
                    // Transfers are word aligned; low address bits are dropped.
                    paddr_d     = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                    pwdata_d    = cmd_wdata;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // PREADY wins even on the cycle the timeout would fire.
                if (PREADY) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? 32'd0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (TO_EN && (wait_q == TO_LAST)) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'd0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (wait_q != 16'hFFFF) begin
                    // Saturate so an unbounded wait never wraps.
                    wait_d = wait_q + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    wait_d      = 16'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= IDLE;
            wait_q        <= 16'd0;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= 32'd0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;

    localparam int AW = 32;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err, rsp_timeout;
    logic [AW-1:0] PADDR;
    logic          PSEL, PENABLE, PWRITE;
    logic [31:0]   PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    int total = 0;
    int bad   = 0;

    apb_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction. The completer answers after nwait low-PREADY
    // cycles; bp is the number of RESP cycles with rsp_ready held low.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input int nwait, input logic [31:0] rd, input logic se,
                          input int bp);
        int          exp_acc, acc;
        logic [31:0] exp_rd;
        logic        exp_err, exp_to;
        logic [31:0] exp_addr;
        // Reference: outcome derived directly from the transfer rules.
        exp_addr = a & 32'hFFFF_FFFC;
        if (TO != 0 && nwait >= TO) begin
            exp_acc = TO; exp_rd = 32'd0; exp_err = 1'b1; exp_to = 1'b1;
        end else begin
            exp_acc = nwait + 1; exp_rd = w ? 32'd0 : rd; exp_err = se; exp_to = 1'b0;
        end

        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
        @(negedge PCLK);
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom_range(0, 1);
        chk("setup_psel", {31'd0, PSEL}, 32'd1);
        chk("setup_penable", {31'd0, PENABLE}, 32'd0);
        chk("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("setup_paddr", PADDR, exp_addr);
        chk("setup_pwrite", {31'd0, PWRITE}, {31'd0, w});
        chk("setup_pwdata", PWDATA, wd);
        @(negedge PCLK);
        acc = 0;
        while (PSEL && PENABLE && acc < 200) begin
            chk("access_paddr", PADDR, exp_addr);
            chk("access_pwdata", PWDATA, wd);
            chk("access_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            if (acc == nwait) begin
                PREADY = 1'b1; PRDATA = rd; PSLVERR = se;
            end else begin
                PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b1;
            end
            acc++;
            @(negedge PCLK);
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
        chk("access_len", acc, exp_acc);
        for (int i = 0; i <= bp; i++) begin
            chk("resp_psel", {31'd0, PSEL}, 32'd0);
            chk("resp_penable", {31'd0, PENABLE}, 32'd0);
            chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("resp_rdata", rsp_rdata, exp_rd);
            chk("resp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            chk("resp_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
            chk("resp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("resp_paddr_hold", PADDR, exp_addr);
            if (i < bp) begin
                rsp_ready = 1'b0;
                @(negedge PCLK);
            end
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_psel", {31'd0, PSEL}, 32'd0);
        chk("rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_flags", {29'd0, PWRITE, rsp_err, rsp_timeout}, 32'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Zero-wait read
        do_txn(1'b0, 32'h0000_0008, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 0);
        // Write, 3 wait states, slave error; ready lands on the timeout cycle
        do_txn(1'b1, 32'h0000_0013, 32'h1234_5678, 3, 32'hAAAA_5555, 1'b1, 0);
        // Timeout with PREADY never asserted
        do_txn(1'b0, 32'h0000_0100, 32'h0, 50, 32'hCAFE_F00D, 1'b0, 0);
        // Response back-pressure
        do_txn(1'b0, 32'h0000_0044, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 5);

        // Reset in the middle of ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0020; cmd_wdata = 32'h5A5A_5A5A;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("mid_access_penable", {31'd0, PENABLE}, 32'd1);
        PRESET = 1'b1;
        #1;
        chk("mid_rst_psel", {31'd0, PSEL}, 32'd0);
        chk("mid_rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        do_txn(1'b0, 32'h0000_0030, 32'h0, 2, 32'h1357_9BDF, 1'b0, 1);

        // Randomized transactions
        for (int n = 0; n < 30; n++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 6),
                   $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
